// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and memory.
// master = sequencer side, slave = memory side.
interface pc_fetch_sequencer_if;
   logic        IMemReqValid;
   logic [63:0] IMemReqAddr;
   logic        IMemReqReady;
   logic        IMemRespValid;
   logic [31:0] IMemRespData;

   modport master (
      output IMemReqValid,
      output IMemReqAddr,
      input  IMemReqReady,
      input  IMemRespValid,
      input  IMemRespData
   );

   modport slave (
      input  IMemReqValid,
      input  IMemReqAddr,
      output IMemReqReady,
      output IMemRespValid,
      output IMemRespData
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: fetches one instruction, holds it for the datapath, commits the
// next PC on ExecDone. Tracks retired instructions and stops on Halt or on a fetch timeout.
module pc_fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                        CLK,
   input  logic                        resetl,
   pc_fetch_sequencer_if.master        imem,
   output logic [31:0]                 Instr,
   output logic                        InstrValid,
   input  logic                        ExecDone,
   input  logic                        Branch,
   input  logic                        ALUZero,
   input  logic                        Uncondbranch,
   input  logic [63:0]                 SignExtImm64,
   input  logic                        Halt,
   output logic [63:0]                 CurrentPC,
   output logic [31:0]                 RetireCount,
   output logic                        Halted,
   output logic                        Fault
);

   // Counter holds 0..TIMEOUT-1; the last value marks the final allowed wait cycle.
   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StFetchReq,
      StFetchWait,
      StExec,
      StHalted,
      StFault
   } state_e;

   state_e          state_q, state_d;
   logic [63:0]     pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [31:0]     retire_q, retire_d;
   logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

   logic        take;
   logic [63:0] pc_offset;
   logic [63:0] next_pc;
   logic        unused_imm_hi;

   // The word-offset shift drops the top two immediate bits.
   assign take          = Uncondbranch | (Branch & ALUZero);
   assign pc_offset     = take ? {SignExtImm64[61:0], 2'b00} : 64'd4;
   assign next_pc       = pc_q + pc_offset;
   assign unused_imm_hi = ^SignExtImm64[63:62];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retire_d  = retire_q;
      tmo_cnt_d = tmo_cnt_q;
      case (state_q)
         StFetchReq: begin
            if (imem.IMemReqReady) begin
               state_d   = StFetchWait;
               tmo_cnt_d = '0;
            end
         end
         StFetchWait: begin
            if (imem.IMemRespValid) begin
               instr_d = imem.IMemRespData;
               state_d = StExec;
            end else if (tmo_cnt_q == CntLast) begin
               state_d = StFault;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CntW'(1);
            end
         end
         StExec: begin
            if (ExecDone) begin
               pc_d     = next_pc;
               retire_d = retire_q + 32'd1;
               state_d  = Halt ? StHalted : StFetchReq;
            end
         end
         StHalted: ;
         StFault:  ;
         default:  state_d = StFetchReq;
      endcase
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q   <= StFetchReq;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retire_q  <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retire_q  <= retire_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign imem.IMemReqValid = (state_q == StFetchReq);
   assign imem.IMemReqAddr  = pc_q;
   assign InstrValid        = (state_q == StExec);
   assign Halted            = (state_q == StHalted);
   assign Fault             = (state_q == StFault);
   assign Instr             = instr_q;
   assign CurrentPC         = pc_q;
   assign RetireCount       = retire_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed instruction stream with a fetch-address scoreboard
// checked by an independent monitor, plus direct checks of reset, halt and timeout behaviour.
module tb_pc_fetch_sequencer;
   localparam logic [63:0] RstPc = 64'h100;
   localparam int unsigned Tmo   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetl;
   logic        exec_done, branch, alu_zero, uncond, halt;
   logic [63:0] imm;
   logic [31:0] instr;
   logic        instr_valid;
   logic [63:0] cur_pc;
   logic [31:0] retire;
   logic        halted, fault;

   pc_fetch_sequencer_if imem_if ();

   pc_fetch_sequencer #(
      .RESET_PC (RstPc),
      .TIMEOUT  (Tmo)
   ) dut (
      .CLK          (clk),
      .resetl       (resetl),
      .imem         (imem_if),
      .Instr        (instr),
      .InstrValid   (instr_valid),
      .ExecDone     (exec_done),
      .Branch       (branch),
      .ALUZero      (alu_zero),
      .Uncondbranch (uncond),
      .SignExtImm64 (imm),
      .Halt         (halt),
      .CurrentPC    (cur_pc),
      .RetireCount  (retire),
      .Halted       (halted),
      .Fault        (fault)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_addr_q[$];
   logic [31:0] exp_retire;
   logic [63:0] req_addr_l;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[33:2] ^ a[63:32] ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted request must match the next scoreboard address.
   always @(negedge clk) begin
      if (resetl === 1'b1 && imem_if.IMemReqValid === 1'b1 && imem_if.IMemReqReady === 1'b1) begin
         if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %h, expected no request",
                     imem_if.IMemReqAddr);
         end else begin
            check("fetch_addr", imem_if.IMemReqAddr, exp_addr_q.pop_front());
         end
      end
      if (resetl === 1'b1 && instr_valid === 1'b1 && exec_done === 1'b1)
         check("instr_word", {32'h0, instr}, {32'h0, mem_word(cur_pc)});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_req(input int ready_wait, output int waited);
      waited = 0;
      while (imem_if.IMemReqValid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check("req_valid", {63'h0, imem_if.IMemReqValid}, 64'h1);
      req_addr_l = imem_if.IMemReqAddr;
      for (int i = 0; i < ready_wait; i++) step();
      if (ready_wait > 0) begin
         check("bp_valid_held", {63'h0, imem_if.IMemReqValid}, 64'h1);
         check("bp_addr_held", imem_if.IMemReqAddr, req_addr_l);
      end
      imem_if.IMemReqReady = 1'b1;
      step();
      imem_if.IMemReqReady = 1'b0;
   endtask

   task automatic respond(input int resp_wait);
      for (int i = 0; i < resp_wait; i++) step();
      imem_if.IMemRespValid = 1'b1;
      imem_if.IMemRespData  = mem_word(req_addr_l);
      step();
      imem_if.IMemRespValid = 1'b0;
      imem_if.IMemRespData  = 32'hDEAD_BEEF;
      check("instr_valid", {63'h0, instr_valid}, 64'h1);
   endtask

   task automatic execute(input int exec_wait, input logic b, input logic az, input logic ub,
                          input logic [63:0] im, input logic h, input logic [63:0] exp_next);
      for (int i = 0; i < exec_wait; i++) step();
      exec_done = 1'b1;
      branch    = b;
      alu_zero  = az;
      uncond    = ub;
      imm       = im;
      halt      = h;
      if (!h) exp_addr_q.push_back(exp_next);
      exp_retire = exp_retire + 32'd1;
      step();
      exec_done = 1'b0;
      branch    = 1'b1;
      alu_zero  = 1'b1;
      uncond    = 1'b1;
      imm       = '1;
      halt      = 1'b1;
      check("retire_count", {32'h0, retire}, {32'h0, exp_retire});
      check("pc_commit", cur_pc, exp_next);
   endtask

   task automatic do_instr(input int rw, input int sw, input int ew, input logic b,
                           input logic az, input logic ub, input logic [63:0] im,
                           input logic h, input logic [63:0] exp_next, output int waited);
      fetch_req(rw, waited);
      respond(sw);
      execute(ew, b, az, ub, im, h, exp_next);
   endtask

   task automatic check_idle(input string name);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (imem_if.IMemReqValid !== 1'b0) bad = 1'b1;
      end
      check(name, {63'h0, bad}, 64'h0);
   endtask

   task automatic reset_pulse();
      resetl = 1'b0;
      step();
      resetl     = 1'b1;
      exp_retire = '0;
      exp_addr_q.push_back(RstPc);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int w;
      resetl                = 1'b0;
      imem_if.IMemReqReady  = 1'b0;
      imem_if.IMemRespValid = 1'b0;
      imem_if.IMemRespData  = '0;
      exec_done = 1'b0; branch = 1'b0; alu_zero = 1'b0; uncond = 1'b0; halt = 1'b0;
      imm        = '0;
      exp_retire = '0;
      repeat (2) step();

      check("rst_req_valid", {63'h0, imem_if.IMemReqValid}, 64'h1);
      check("rst_req_addr", imem_if.IMemReqAddr, RstPc);
      check("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
      check("rst_instr", {32'h0, instr}, 64'h0);
      check("rst_retire", {32'h0, retire}, 64'h0);
      check("rst_halted", {63'h0, halted}, 64'h0);
      check("rst_fault", {63'h0, fault}, 64'h0);

      resetl = 1'b1;
      exp_addr_q.push_back(RstPc);

      // Back-to-back sequential fetch: each request must issue with no idle cycle.
      do_instr(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h104, w);
      check("period_0", 64'(w), 64'h0);
      do_instr(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h108, w);
      check("period_1", 64'(w), 64'h0);
      do_instr(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h10C, w);
      check("period_2", 64'(w), 64'h0);
      check("retire_after_3", {32'h0, retire}, 64'd3);

      do_instr(0, 0, 0, 0, 0, 1, 64'h3D, 0, 64'h200, w);
      check("period_3", 64'(w), 64'h0);
      do_instr(5, 0, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h1F8, w);
      do_instr(0, 0, 0, 0, 0, 1, 64'h2, 0, 64'h200, w);
      do_instr(0, 0, 0, 0, 0, 1, 64'd16, 0, 64'h240, w);
      do_instr(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'h200, w);
      do_instr(0, 0, 2, 1, 0, 0, 64'd100, 0, 64'h204, w);
      // Response on the last allowed wait cycle; immediate's top bits are shifted out.
      do_instr(0, Tmo - 1, 0, 0, 0, 1, 64'hC000_0000_0000_0003, 0, 64'h210, w);
      do_instr(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF7B, 0, 64'hFFFF_FFFF_FFFF_FFFC, w);
      do_instr(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, w);
      do_instr(0, 0, 0, 0, 0, 1, 64'd4, 0, 64'h10, w);
      do_instr(0, 0, 0, 0, 0, 0, 64'h0, 1, 64'h14, w);

      check("halted", {63'h0, halted}, 64'h1);
      check("halt_retire", {32'h0, retire}, 64'd14);
      check_idle("halt_no_fetch");
      check("halt_pc_hold", cur_pc, 64'h14);
      check("halt_sticky", {63'h0, halted}, 64'h1);

      // Asynchronous reset in the middle of FETCH_WAIT.
      reset_pulse();
      fetch_req(0, w);
      #3;
      resetl = 1'b0;
      #1;
      check("arst_wait_req_valid", {63'h0, imem_if.IMemReqValid}, 64'h1);
      check("arst_wait_addr", imem_if.IMemReqAddr, RstPc);
      check("arst_wait_halted", {63'h0, halted}, 64'h0);
      step();
      resetl = 1'b1;
      exp_addr_q.push_back(RstPc);
      do_instr(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h104, w);

      // Asynchronous reset in the middle of EXEC.
      fetch_req(0, w);
      respond(0);
      #3;
      resetl = 1'b0;
      #1;
      check("arst_exec_instr_valid", {63'h0, instr_valid}, 64'h0);
      check("arst_exec_instr", {32'h0, instr}, 64'h0);
      check("arst_exec_pc", cur_pc, RstPc);
      check("arst_exec_retire", {32'h0, retire}, 64'h0);
      check("arst_exec_req_valid", {63'h0, imem_if.IMemReqValid}, 64'h1);
      step();
      resetl     = 1'b1;
      exp_retire = '0;
      exp_addr_q.push_back(RstPc);

      // Fetch timeout: no response at all.
      fetch_req(0, w);
      for (int i = 0; i < int'(Tmo) - 1; i++) step();
      check("fault_not_early", {63'h0, fault}, 64'h0);
      step();
      check("fault_set", {63'h0, fault}, 64'h1);
      check("fault_pc", cur_pc, RstPc);
      check_idle("fault_no_fetch");
      check("fault_sticky", {63'h0, fault}, 64'h1);
      check("fault_retire", {32'h0, retire}, 64'h0);

      check("scoreboard_empty", 64'(exp_addr_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Multi-cycle fetch/sequence controller that owns the program counter, fetches each instruction from instruction memory over a valid/ready request plus valid response handshake, holds it for the datapath, and commits the next PC when the datapath reports completion. Next-PC selection matches the datapath's branch rule: PC+4, or PC + 4·SignExtImm64 when `Uncondbranch | (Branch & ALUZero)`. It also provides a retired-instruction counter, halt handling, and a fetch-timeout fault.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned
- TIMEOUT, 16, maximum cycles spent in FETCH_WAIT before faulting (≥1)
- CLK  in  1  clock; all state updates on the rising edge
- resetl  in  1  reset, asynchronous, active-low
- IMemReqValid  out  1  fetch request valid
- IMemReqAddr  out  64  fetch address (= CurrentPC)
- IMemReqReady  in  1  memory accepts the request
- IMemRespValid  in  1  instruction word valid
- IMemRespData  in  32  instruction word
- Instr  out  32  latched instruction for the datapath
- InstrValid  out  1  Instr valid; datapath may execute
- ExecDone  in  1  datapath finished the current instruction; sampled only in EXEC
- Branch, ALUZero, Uncondbranch  in  1 each  branch controls; sampled with ExecDone
- SignExtImm64  in  64  sign-extended word offset; sampled with ExecDone
- Halt  in  1  current instruction is the last one; sampled with ExecDone
- CurrentPC  out  64  architectural PC
- RetireCount  out  32  instructions committed
- Halted  out  1  sequencer stopped by Halt
- Fault  out  1  fetch timeout occurred

## Operation
- States: FETCH_REQ, FETCH_WAIT, EXEC, HALTED, FAULT. Encoding is free.
- Reset (resetl low, any time, mid-handshake included) forces the following immediately: state=FETCH_REQ, CurrentPC=RESET_PC, Instr=0, RetireCount=0, and the timeout counter=0. All outputs take their reset values: IMemReqValid=1 (driven from state), InstrValid=0, Halted=0, Fault=0. An outstanding memory transaction is abandoned. Memory must tolerate this.
- FETCH_REQ:
  - IMemReqValid=1 and IMemReqAddr=CurrentPC, held stable until IMemReqReady.
  - On Valid&Ready, go to FETCH_WAIT.
  - IMemRespValid is ignored in this state.
- FETCH_WAIT:
  - IMemReqValid=0.
  - On IMemRespValid, latch IMemRespData into Instr and go to EXEC.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no response, go to FAULT.
  - The counter clears on every entry to FETCH_WAIT.
- EXEC:
  - InstrValid=1. Instr and CurrentPC are held constant.
  - On ExecDone:
    - CurrentPC ← NextPC.
    - RetireCount ← RetireCount+1.
    - If Halt, go to HALTED. Otherwise go to FETCH_REQ.
- NextPC:
  - take = Uncondbranch | (Branch & ALUZero).
  - take=0: CurrentPC + 64'd4.
  - take=1: CurrentPC + (SignExtImm64 << 2).
  - All arithmetic is modulo 2^64. Wrap-around is silent, with no fault (e.g. PC 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
  - The shift discards SignExtImm64[63:62].
- HALTED: Halted=1. No fetch. Sticky until reset. PC and RetireCount hold the committed values.
- FAULT: Fault=1. No fetch. CurrentPC stays at the address that timed out. Sticky until reset.
- RetireCount wraps from 32'hFFFF_FFFF to 0 without a flag.
- Branch, ALUZero, Uncondbranch, SignExtImm64 and Halt are don't-care outside EXEC&ExecDone.

## Timing
- All outputs are registered state or decoded from the state register. There are no combinational paths from inputs to outputs.
- Minimum instruction period is 3 cycles, with request accepted and response arriving the cycle after:
  - cycle 0: FETCH_REQ with Ready.
  - cycle 1: FETCH_WAIT with RespValid.
  - cycle 2: EXEC with ExecDone.
  - cycle 3: the new request issues.
- IMemReqAddr reflects the new PC on the first FETCH_REQ cycle after commit.
- Backpressure: any number of cycles with Ready=0 in FETCH_REQ or ExecDone=0 in EXEC is allowed; there is no timeout in those states.
- Timeout: a response arriving on the TIMEOUT-th FETCH_WAIT cycle is accepted. Fault asserts if none has arrived by the cycle after that.
- Deassertion of resetl is synchronous in effect. The first request handshake can complete on the first rising edge after release.

## Test plan
- **Reset/sequential:** RESET_PC=0x100; memory with 1-cycle Ready and response; ExecDone 1 cycle after InstrValid, never branching. Required: IMemReqAddr sequence 0x100, 0x104, 0x108; RetireCount=3 after three commits; 3-cycle period.
- **Taken branch, both forms:**
  - At PC 0x200, Branch=1, ALUZero=1, SignExtImm64=-2 → next IMemReqAddr=0x1F8.
  - Uncondbranch=1, imm=+16 → 0x240.
  - Branch=1, ALUZero=0 → 0x204.
- **Wrap-around:** RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, no branch → next fetch at 0.
- **Backpressure and timeout:**
  - Ready low 5 cycles → address held stable, no state change.
  - TIMEOUT=4, response on the 4th FETCH_WAIT cycle → accepted.
  - No response → Fault=1, no further requests, CurrentPC unchanged.
- **Halt:** Halt=1 with ExecDone at PC 0x10 → Halted=1, CurrentPC=0x14, RetireCount incremented, IMemReqValid stays 0 for 20 cycles.
- **Reset mid-operation:** drop resetl asynchronously during FETCH_WAIT and during EXEC (between clock edges). Required: outputs return to reset values immediately, and after release fetch restarts at RESET_PC.
